// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 6;

  // 2'd3 is unused; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester, acknowledge and RAM-pin bundle around the data RAM arbiter.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] q0;
  logic [DATA_WIDTH-1:0] q1;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  busy;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, data0, data1, ram_q,
    output ack0, ack1, q0, q1, ram_data, ram_read_addr, ram_write_addr,
           ram_we, busy
  );

  // Requester side (both ports).
  modport master (
    output req0, req1, we0, we1, addr0, addr1, data0, data1,
    input  ack0, ack1, q0, q1, busy
  );

  // RAM instance side.
  modport mem (
    input  ram_data, ram_read_addr, ram_write_addr, ram_we,
    output ram_q
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the port not granted last wins.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = PORT_CPU;
    case (req)
      2'b01:   grant_idx = PORT_CPU;
      2'b10:   grant_idx = PORT_IO;
      2'b11:   grant_idx = ~last;
      default: grant_idx = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the data RAM between the CPU port and the I/O port,
// with a fixed IDLE -> ACCESS -> DONE transaction per grant.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
)
(
  input  logic          clock,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  state_t                state;
  state_t                next_state;
  logic                  sel;
  logic                  sel_nxt;
  logic                  last;
  logic                  last_nxt;
  logic                  ack0_r;
  logic                  ack0_nxt;
  logic                  ack1_r;
  logic                  ack1_nxt;
  logic [DATA_WIDTH-1:0] q0_r;
  logic [DATA_WIDTH-1:0] q0_nxt;
  logic [DATA_WIDTH-1:0] q1_r;
  logic [DATA_WIDTH-1:0] q1_nxt;

  logic                  grant_valid;
  logic                  grant_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter2 u_rr (
    .req         ({bus.req1, bus.req0}),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the registered grant, ack and read-data updates.
  always_comb begin
    next_state = state;
    sel_nxt    = sel;
    last_nxt   = last;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    q0_nxt     = q0_r;
    q1_nxt     = q1_r;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state = ACCESS;
          sel_nxt    = grant_idx;
          last_nxt   = grant_idx;
        end
      end
      ACCESS: begin
        next_state = DONE;
        // Completion edge: the RAM captures writes, the winner captures reads.
        if (sel == PORT_CPU) begin
          ack0_nxt = 1'b1;
          if (!bus.we0) q0_nxt = bus.ram_q;
        end else begin
          ack1_nxt = 1'b1;
          if (!bus.we1) q1_nxt = bus.ram_q;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant, fairness history, acks and read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel    <= PORT_CPU;
      last   <= PORT_IO;
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      q0_r   <= '0;
      q1_r   <= '0;
    end else begin
      sel    <= sel_nxt;
      last   <= last_nxt;
      ack0_r <= ack0_nxt;
      ack1_r <= ack1_nxt;
      q0_r   <= q0_nxt;
      q1_r   <= q1_nxt;
    end
  end

  // RAM pins follow the selected port; only the write enable is qualified by state.
  assign sel_we   = (sel == PORT_IO) ? bus.we1   : bus.we0;
  assign sel_addr = (sel == PORT_IO) ? bus.addr1 : bus.addr0;
  assign sel_data = (sel == PORT_IO) ? bus.data1 : bus.data0;

  assign bus.ram_read_addr  = sel_addr;
  assign bus.ram_write_addr = sel_addr;
  assign bus.ram_data       = sel_data;
  assign bus.ram_we         = (state == ACCESS) && sel_we;

  assign bus.ack0 = ack0_r;
  assign bus.ack1 = ack1_r;
  assign bus.q0   = q0_r;
  assign bus.q1   = q1_r;
  assign bus.busy = (state != IDLE);

endmodule
